motor_pwm_driver: RTL and testbench
===================================

// Module: motor_pwm_driver
// PURPOSE
//  Consumer side of the motion-logic command interface. Samples per-driver direction codes and 3-digit BCD
//  duty factors, then generates the H-bridge inputs (IN1..IN4) and PWM enables (ENA/ENB) for the dual driver.
//  Uses one shared PWM period counter and one FSM per channel. The FSM inserts dead periods on direction reversal.
// PARAMETERS
//  PRESC         2    clk cycles per PWM counter step (50 MHz / (2*1000) = 25 kHz PWM)
//  DEAD_PERIODS  4    full PWM periods with bridge off on a FWD<->REV reversal (0 = reverse directly)
//  RAMP_STEP     10   max applied-duty increase per PWM period (binary units), used only with SOFT_START_EN
// PORTS
//  clk                input   1   system clock, 50 MHz
//  rst_n              input   1   asynchronous reset, active low
//  directie_driverA   input   2   channel A command: 10 FWD, 01 REV, 00 STOP, 11 invalid (treated as STOP)
//  directie_driverB   input   2   channel B command, same coding
//  factor_dc_driverA  input   12  channel A duty, BCD 000..999
//  factor_dc_driverB  input   12  channel B duty, BCD 000..999
//  in1, in2           output  1   channel A bridge inputs (FWD: 1,0; REV: 0,1; else 0,0)
//  in3, in4           output  1   channel B bridge inputs, same mapping
//  ena, enb           output  1   channel PWM enables
//  stare_A, stare_B   output  2   channel FSM state for LEDs: 00 IDLE, 01 RUN, 10 DEAD
// BEHAVIOUR
//  - Reset state (asynchronous, all registered): every output 0; counter 0; prescaler 0; both FSMs IDLE;
//    applied direction STOP; applied duty 0.
//  - Prescaler counts 0..PRESC-1 and issues a 1-clk tick at PRESC-1.
//  - The period counter advances on each tick, 0..999, and wraps 999->0.
//  - period_start is a 1-clk pulse on the tick that wraps the counter to 0.
//  - Commands and duties are sampled only at period_start. Changes within a period have no effect until the next one.
//    Command-to-output latency is at most 1 period + 2 clk.
//  - BCD-to-binary conversion: any nibble >9 is clamped to 9, so 12'hAFF -> 999.
//  - PWM: en = (state==RUN) && (cnt < duty_applied). Outputs are registered, so en lags the counter by 1 clk.
//    duty 0 -> en never high; duty 999 -> high 999 of 1000 counts.
//  - Per-channel FSM; all transitions happen at period_start using the sampled cmd:
//    IDLE: cmd FWD/REV -> RUN, dir=cmd; otherwise stay. in=00, en=0.
//    RUN: cmd==dir -> stay and update duty.
//         cmd STOP/11 -> IDLE.
//         cmd opposite -> DEAD with dead_cnt=DEAD_PERIODS (goes straight to RUN with new dir if DEAD_PERIODS=0).
//    DEAD: in=00, en=0. dead_cnt decrements each period_start.
//          When dead_cnt reaches 0 -> RUN with the latest FWD/REV cmd.
//          cmd STOP/11 at any boundary -> IDLE immediately.
//  - Both channels are independent; simultaneous reversals on A and B are legal.
//  - rst_n asserted mid-DEAD or mid-period: all outputs 0 immediately. After release the first sample is at the next wrap.
// CONFIGURATION
//  SOFT_START_EN defined:
//    - Entering RUN sets duty_applied=0.
//    - Each period_start: duty_applied = min(target, duty_applied+RAMP_STEP).
//    - A decrease to a lower target is applied immediately.
//  SOFT_START_EN undefined: duty_applied = target at every period_start in RUN.
// STRUCTURE
//  motor_pwm_pkg:
//    - direction codes DIR_FWD/DIR_REV/DIR_STOP
//    - state codes ST_IDLE/ST_RUN/ST_DEAD
//    - PWM_TOP=999
//    - function bcd3_to_bin (with clamp)
//  Top level holds the prescaler, period counter and period_start.
//  Sub-module motor_pwm_channel (FSM, dead counter, duty/ramp, output regs) is instantiated twice.
// TESTING
//  1. Reset, then A=FWD with duty 999 -> after 1st wrap in1=1, in2=0; ena high 999*PRESC clk per 1000*PRESC clk period.
//  2. Duty 500 -> ena high exactly 500 counts. Duty 000 -> ena stays 0. Duty 12'hAFF -> behaves as 999.
//  3. RUN FWD then cmd REV (DEAD_PERIODS=4) -> stare_A=10 and in1=in2=ena=0 for 4 periods; then in1=0, in2=1, RUN.
//  4. RUN then cmd 00, and separately cmd 11 -> at next boundary in=00, en=0, stare=IDLE. Mid-period cmd changes are ignored.
//  5. rst_n pulsed low mid-DEAD -> all outputs 0 asynchronously; after release, IDLE until the next wrap samples cmd.
//  6. SOFT_START_EN, duty 0->999, RAMP_STEP=10 -> applied duty 10,20,..., reaching 999 at period 100.
//     Without the macro -> 999 in the 1st period.

Source files
------------

// File: rtl/motor_pwm_pkg.sv
// Shared definitions for the dual H-bridge PWM driver: direction and state codes,
// the PWM counter top value, and the clamping BCD-to-binary duty conversion.
package motor_pwm_pkg;

    typedef enum logic [1:0] {
        DIR_STOP = 2'b00,
        DIR_REV  = 2'b01,
        DIR_FWD  = 2'b10
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_e;

    localparam int PWM_TOP = 999;
    localparam int CNT_W   = 10;

    // Nibbles above 9 saturate to 9, so 12'hAFF reads as 999.
    function automatic logic [CNT_W-1:0] bcd3_to_bin(input logic [11:0] bcd);
        logic [3:0] d2, d1, d0;
        d2 = (bcd[11:8] > 4'd9) ? 4'd9 : bcd[11:8];
        d1 = (bcd[7:4]  > 4'd9) ? 4'd9 : bcd[7:4];
        d0 = (bcd[3:0]  > 4'd9) ? 4'd9 : bcd[3:0];
        return 10'(d2) * 10'd100 + 10'(d1) * 10'd10 + 10'(d0);
    endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// One H-bridge channel: command FSM, dead-period counter, applied duty and registered bridge outputs.
// SOFT_START_EN enables the per-period duty ramp on the way up.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   ST_IDLE | bridge off, waiting for a FWD/REV command at a period boundary
//   ST_RUN  | bridge driven in dir_q, PWM enable from counter vs applied duty
//   ST_DEAD | bridge off for dead_q more periods after a direction reversal
module motor_pwm_channel
    import motor_pwm_pkg::*;
#(
    parameter int DEAD_PERIODS = 4,
    parameter int RAMP_STEP    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             period_start_i,
    input  logic [1:0]       cmd_i,
    input  logic [11:0]      duty_bcd_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             in_a_o,
    output logic             in_b_o,
    output logic             en_o,
    output logic [1:0]       state_o
);

    localparam int DW = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;

    state_e           state_q, state_d;
    logic [1:0]       dir_q, dir_d;
    logic [DW-1:0]    dead_q, dead_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] target, duty_run, duty_entry;
    logic             cmd_run;
    logic             in_a_q, in_b_q, en_q;

    function automatic logic [CNT_W-1:0] ramp(input logic [CNT_W-1:0] cur,
                                              input logic [CNT_W-1:0] tgt);
        logic [CNT_W:0] sum;
        sum = {1'b0, cur} + (CNT_W+1)'(RAMP_STEP);
        if (tgt <= cur || sum >= {1'b0, tgt}) return tgt;
        return sum[CNT_W-1:0];
    endfunction

    assign target  = bcd3_to_bin(duty_bcd_i);
    assign cmd_run = (cmd_i == DIR_FWD) || (cmd_i == DIR_REV);

`ifdef SOFT_START_EN
    assign duty_run   = ramp(duty_q, target);
    assign duty_entry = ramp('0, target);
`else
    assign duty_run   = target;
    assign duty_entry = target;
`endif

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        dead_d  = dead_q;
        duty_d  = duty_q;
        if (period_start_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_run) begin
                        state_d = ST_RUN;
                        dir_d   = cmd_i;
                        duty_d  = duty_entry;
                    end
                end
                ST_RUN: begin
                    if (!cmd_run) begin
                        state_d = ST_IDLE;
                        duty_d  = '0;
                    end else if (cmd_i == dir_q) begin
                        duty_d = duty_run;
                    end else if (DEAD_PERIODS == 0) begin
                        dir_d  = cmd_i;
                        duty_d = duty_entry;
                    end else begin
                        state_d = ST_DEAD;
                        dead_d  = DW'(DEAD_PERIODS);
                        duty_d  = '0;
                    end
                end
                ST_DEAD: begin
                    // Leaving on the boundary where the count would hit zero gives exactly DEAD_PERIODS dark periods.
                    if (!cmd_run) begin
                        state_d = ST_IDLE;
                    end else if (dead_q <= DW'(1)) begin
                        state_d = ST_RUN;
                        dir_d   = cmd_i;
                        duty_d  = duty_entry;
                        dead_d  = '0;
                    end else begin
                        dead_d = dead_q - DW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_STOP;
            dead_q  <= '0;
            duty_q  <= '0;
            in_a_q  <= 1'b0;
            in_b_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            dead_q  <= dead_d;
            duty_q  <= duty_d;
            in_a_q  <= (state_q == ST_RUN) && (dir_q == DIR_FWD);
            in_b_q  <= (state_q == ST_RUN) && (dir_q == DIR_REV);
            en_q    <= (state_q == ST_RUN) && (cnt_i < duty_q);
        end
    end

    assign in_a_o  = in_a_q;
    assign in_b_o  = in_b_q;
    assign en_o    = en_q;
    assign state_o = state_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// Dual-channel motor PWM driver: shared prescaler and 0..999 period counter feeding two channel FSMs.
// Optional duty soft start is built in when SOFT_START_EN is defined.
module motor_pwm_driver
    import motor_pwm_pkg::*;
#(
    parameter int PRESC        = 2,
    parameter int DEAD_PERIODS = 4,
    parameter int RAMP_STEP    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  directie_driverA,
    input  logic [1:0]  directie_driverB,
    input  logic [11:0] factor_dc_driverA,
    input  logic [11:0] factor_dc_driverB,
    output logic        in1,
    output logic        in2,
    output logic        in3,
    output logic        in4,
    output logic        ena,
    output logic        enb,
    output logic [1:0]  stare_A,
    output logic [1:0]  stare_B
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick, period_start;

    assign tick         = (presc_q == PW'(PRESC - 1));
    assign period_start = tick && (cnt_q == CNT_W'(PWM_TOP));

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        cnt_d   = cnt_q;
        if (tick) cnt_d = (cnt_q == CNT_W'(PWM_TOP)) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    motor_pwm_channel #(.DEAD_PERIODS(DEAD_PERIODS), .RAMP_STEP(RAMP_STEP)) u_ch_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .period_start_i (period_start),
        .cmd_i          (directie_driverA),
        .duty_bcd_i     (factor_dc_driverA),
        .cnt_i          (cnt_q),
        .in_a_o         (in1),
        .in_b_o         (in2),
        .en_o           (ena),
        .state_o        (stare_A)
    );

    motor_pwm_channel #(.DEAD_PERIODS(DEAD_PERIODS), .RAMP_STEP(RAMP_STEP)) u_ch_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .period_start_i (period_start),
        .cmd_i          (directie_driverB),
        .duty_bcd_i     (factor_dc_driverB),
        .cnt_i          (cnt_q),
        .in_a_o         (in3),
        .in_b_o         (in4),
        .en_o           (enb),
        .state_o        (stare_B)
    );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver: per-period enable counts, bridge pins and FSM states.
module tb_motor_pwm_driver;

    logic        clk;
    logic        rst_n;
    logic [1:0]  dir_a, dir_b;
    logic [11:0] duty_a, duty_b;
    logic        in1, in2, in3, in4, ena, enb;
    logic [1:0]  stare_A, stare_B;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    int         hi_a, hi_b;
    logic [1:0] s_a, s_b;
    logic       p1, p2, p3, p4;

    motor_pwm_driver dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .directie_driverA  (dir_a),
        .directie_driverB  (dir_b),
        .factor_dc_driverA (duty_a),
        .factor_dc_driverB (duty_b),
        .in1               (in1),
        .in2               (in2),
        .in3               (in3),
        .in4               (in4),
        .ena               (ena),
        .enb               (enb),
        .stare_A           (stare_A),
        .stare_B           (stare_B)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One full PWM period (2000 clk). The next period's commands are applied early in this one,
    // so the measured counts also show that mid-period changes are not picked up.
    task automatic run_period(input logic [1:0] na, input logic [11:0] da,
                              input logic [1:0] nb, input logic [11:0] db);
        hi_a = 0;
        hi_b = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                s_a = stare_A; s_b = stare_B;
                p1 = in1; p2 = in2; p3 = in3; p4 = in4;
            end
            if (ena) hi_a++;
            if (enb) hi_b++;
            if (i == 100) begin
                dir_a = na; duty_a = da;
                dir_b = nb; duty_b = db;
            end
        end
    endtask

    function automatic int all_outs();
        return int'({in1, in2, in3, in4, ena, enb, stare_A, stare_B});
    endfunction

    initial begin
        rst_n  = 1'b0;
        dir_a  = 2'b00; dir_b  = 2'b00;
        duty_a = 12'h000; duty_b = 12'h000;
        #5;
        chk("reset_outputs", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SOFT_START_EN
        run_period(2'b10, 12'h999, 2'b00, 12'h000);
        chk("ss_p0_state_a", s_a, 0);
        chk("ss_p0_ena", hi_a, 0);
        run_period(2'b10, 12'h999, 2'b00, 12'h000);
        chk("ss_p1_state_a", s_a, 1);
        chk("ss_p1_in1", p1, 1);
        chk("ss_p1_ena_duty10", hi_a, 20);
        run_period(2'b10, 12'h999, 2'b00, 12'h000);
        chk("ss_p2_ena_duty20", hi_a, 40);
        run_period(2'b10, 12'h025, 2'b00, 12'h000);
        chk("ss_p3_ena_duty30", hi_a, 60);
        run_period(2'b10, 12'h025, 2'b00, 12'h000);
        chk("ss_p4_ena_drop25", hi_a, 50);
        chk("ss_p4_enb", hi_b, 0);
        run_period(2'b10, 12'h025, 2'b00, 12'h000);
        chk("ss_p5_ena_hold25", hi_a, 50);
`else
        // P0: reset state until the first wrap
        run_period(2'b10, 12'h999, 2'b00, 12'h000);
        chk("p0_state_a", s_a, 0);
        chk("p0_ena", hi_a, 0);
        chk("p0_in1", p1, 0);
        // P1: A FWD 999
        run_period(2'b10, 12'h500, 2'b01, 12'hAFF);
        chk("p1_state_a", s_a, 1);
        chk("p1_in1", p1, 1);
        chk("p1_in2", p2, 0);
        chk("p1_ena_999", hi_a, 1998);
        chk("p1_state_b", s_b, 0);
        chk("p1_enb", hi_b, 0);
        // P2: A duty 500, B REV AFF
        run_period(2'b10, 12'h000, 2'b01, 12'hAFF);
        chk("p2_ena_500", hi_a, 1000);
        chk("p2_state_b", s_b, 1);
        chk("p2_in3", p3, 0);
        chk("p2_in4", p4, 1);
        chk("p2_enb_aff", hi_b, 1998);
        // P3: A duty 0, B still running
        run_period(2'b01, 12'h500, 2'b00, 12'h000);
        chk("p3_ena_000", hi_a, 0);
        chk("p3_in1", p1, 1);
        chk("p3_state_a", s_a, 1);
        chk("p3_enb", hi_b, 1998);
        // P4..P7: A dead after reversal; B stop, run, invalid
        run_period(2'b01, 12'h500, 2'b10, 12'h250);
        chk("p4_state_a", s_a, 2);
        chk("p4_in_a", {30'd0, p1, p2}, 0);
        chk("p4_ena", hi_a, 0);
        chk("p4_state_b", s_b, 0);
        chk("p4_in_b", {30'd0, p3, p4}, 0);
        run_period(2'b01, 12'h500, 2'b11, 12'h250);
        chk("p5_state_a", s_a, 2);
        chk("p5_state_b", s_b, 1);
        chk("p5_in3", p3, 1);
        chk("p5_enb_250", hi_b, 500);
        run_period(2'b01, 12'h500, 2'b00, 12'h000);
        chk("p6_state_a", s_a, 2);
        chk("p6_state_b_inv", s_b, 0);
        chk("p6_enb", hi_b, 0);
        run_period(2'b01, 12'h500, 2'b10, 12'h999);
        chk("p7_state_a", s_a, 2);
        chk("p7_ena", hi_a, 0);
        // P8: A running REV after 4 dead periods
        run_period(2'b10, 12'h500, 2'b10, 12'h999);
        chk("p8_state_a", s_a, 1);
        chk("p8_in1", p1, 0);
        chk("p8_in2", p2, 1);
        chk("p8_ena_500", hi_a, 1000);
        chk("p8_enb", hi_b, 1998);
        // P9: A dead again, reset pulsed mid-period
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
        end
        chk("p9_state_a", stare_A, 2);
        chk("p9_enb_pre", enb, 1);
        chk("p9_in3_pre", in3, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_period(2'b10, 12'h700, 2'b00, 12'h000);
        chk("r0_state_a", s_a, 0);
        chk("r0_ena", hi_a, 0);
        chk("r0_enb", hi_b, 0);
        run_period(2'b10, 12'h700, 2'b00, 12'h000);
        chk("r1_state_a", s_a, 1);
        chk("r1_in1", p1, 1);
        chk("r1_ena_700", hi_a, 1400);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
